keypad_scanner: RTL and testbench

Front-end for the combination lock: scans a 4×4 active-low matrix keypad plus two discrete buttons (ENTER, CLEAR), debounces the result, and delivers each accepted keystroke as a one-cycle `newkey` pulse with a stable 5-bit `keycode`. It sits directly upstream of the lock's control/checker logic and drives its `newkey`/`keycode` inputs one-to-one.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_debounce.sv | 101 ++++++++++
 rtl/keypad_scanner.sv | 96 +++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key codes and key map for the keypad scanner
package keypad_pkg;

   localparam logic [4:0] KEY_ENTER = 5'h10;
   localparam logic [4:0] KEY_CLEAR = 5'h11;

   typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;

   typedef struct packed {
      scan_kind_e kind;
      logic [4:0] code;
   } scan_result_t;

   typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD} db_state_e;

   function automatic logic [4:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [4:0] k;
      case ({row, col})
         4'h0: k = 5'h01;
         4'h1: k = 5'h02;
         4'h2: k = 5'h03;
         4'h3: k = 5'h0A;
         4'h4: k = 5'h04;
         4'h5: k = 5'h05;
         4'h6: k = 5'h06;
         4'h7: k = 5'h0B;
         4'h8: k = 5'h07;
         4'h9: k = 5'h08;
         4'hA: k = 5'h09;
         4'hB: k = 5'h0C;
         4'hC: k = 5'h0E;
         4'hD: k = 5'h00;
         4'hE: k = 5'h0F;
         default: k = 5'h0D;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix, buttons and keystroke output bundle
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic       btn_enter;
   logic       btn_clear;
   logic [3:0] col_n;
   logic       newkey;
   logic [4:0] keycode;

   modport master (input row_n, btn_enter, btn_clear, output col_n, newkey, keycode);
   modport slave  (output row_n, btn_enter, btn_clear, input col_n, newkey, keycode);
endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - press/release qualification of per-scan results
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic         clk5,
   input  logic         reset,
   input  logic         scan_end,
   input  scan_result_t result,
   output logic         newkey,
   output logic [4:0]   keycode
);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS - 1);

   db_state_e   state_q, state_d;
   logic [4:0]  cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rel_q, rel_d;
   logic        newkey_q, newkey_d;
   logic [4:0]  keycode_q, keycode_d;

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      rel_d     = rel_q;
      newkey_d  = 1'b0;
      keycode_d = keycode_q;
      if (scan_end) begin
         case (state_q)
            ST_IDLE: begin
               if (result.kind == SCAN_SINGLE) begin
                  cand_d = result.code;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d   = ST_HELD;
                     rel_d     = '0;
                     newkey_d  = 1'b1;
                     keycode_d = result.code;
                  end else begin
                     state_d = ST_CAND;
                     cnt_d   = CW'(1);
                  end
               end
            end
            ST_CAND: begin
               if (result.kind == SCAN_SINGLE && result.code == cand_q) begin
                  if (cnt_q == LAST) begin
                     state_d   = ST_HELD;
                     cnt_d     = '0;
                     rel_d     = '0;
                     newkey_d  = 1'b1;
                     keycode_d = cand_q;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            ST_HELD: begin
               // Only an unbroken run of empty scans re-arms the lock input.
               if (result.kind == SCAN_NONE) begin
                  if (rel_q == LAST) begin
                     state_d = ST_IDLE;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_q + 1'b1;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk5 or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cand_q    <= '0;
         cnt_q     <= '0;
         rel_q     <= '0;
         newkey_q  <= 1'b0;
         keycode_q <= '0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         rel_q     <= rel_d;
         newkey_q  <= newkey_d;
         keycode_q <= keycode_d;
      end
   end

   assign newkey  = newkey_q;
   assign keycode = keycode_q;
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix plus ENTER/CLEAR scanner feeding the lock logic
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input logic               clk5,
   input logic               reset,
   keypad_scanner_if.master  kp
);
   localparam int DW = $clog2(SCAN_DIV);

   logic [3:0]    row_s1_q, row_s2_q;
   logic [1:0]    btn_s1_q, btn_s2_q;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    col_n_q, col_n_d;
   logic [1:0]    hits_q, hits_d;
   logic [4:0]    code_q, code_d;
   logic          sample;
   logic          scan_end;
   scan_result_t  result;

   always_comb begin
      sample   = (div_q == DW'(SCAN_DIV - 1));
      scan_end = sample && (col_q == 2'd3);
      div_d    = sample ? '0 : div_q + 1'b1;
      col_d    = sample ? col_q + 2'd1 : col_q;
      col_n_d  = ~(4'b0001 << col_d);
      hits_d   = hits_q;
      code_d   = code_q;
      // hits saturates at 2: anything beyond one key is simply MULTI.
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
               hits_d = (hits_d == 2'd0) ? 2'd1 : 2'd2;
               code_d = keymap(2'(r), col_q);
            end
         end
         if (col_q == 2'd3 && btn_s2_q[0]) begin
            hits_d = (hits_d == 2'd0) ? 2'd1 : 2'd2;
            code_d = KEY_ENTER;
         end
         if (col_q == 2'd3 && btn_s2_q[1]) begin
            hits_d = (hits_d == 2'd0) ? 2'd1 : 2'd2;
            code_d = KEY_CLEAR;
         end
      end
      result.code = code_d;
      case (hits_d)
         2'd0:    result.kind = SCAN_NONE;
         2'd1:    result.kind = SCAN_SINGLE;
         default: result.kind = SCAN_MULTI;
      endcase
      if (scan_end) begin
         hits_d = '0;
         code_d = '0;
      end
   end

   always_ff @(posedge clk5 or posedge reset) begin
      if (reset) begin
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         div_q    <= '0;
         col_q    <= '0;
         col_n_q  <= 4'b1110;
         hits_q   <= '0;
         code_q   <= '0;
      end else begin
         row_s1_q <= kp.row_n;
         row_s2_q <= row_s1_q;
         btn_s1_q <= {kp.btn_clear, kp.btn_enter};
         btn_s2_q <= btn_s1_q;
         div_q    <= div_d;
         col_q    <= col_d;
         col_n_q  <= col_n_d;
         hits_q   <= hits_d;
         code_q   <= code_d;
      end
   end

   assign kp.col_n = col_n_q;

   keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
      .clk5     (clk5),
      .reset    (reset),
      .scan_end (scan_end),
      .result   (result),
      .newkey   (kp.newkey),
      .keycode  (kp.keycode)
   );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized and directed bench for keypad_scanner
module tb_keypad_scanner;
   localparam int D = 3;
   localparam int SCAN = 16;

   logic        clk5 = 1'b0;
   logic        reset = 1'b0;
   logic [17:0] keys = '0;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          cyc = 0;
   int          first_pulse_cyc = -1;

   // key index r*4+c for the matrix, 16 = ENTER, 17 = CLEAR
   logic [4:0] code_tab [16] = '{5'h01, 5'h02, 5'h03, 5'h0A, 5'h04, 5'h05, 5'h06, 5'h0B,
                                 5'h07, 5'h08, 5'h09, 5'h0C, 5'h0E, 5'h00, 5'h0F, 5'h0D};

   bit         armed;
   int         streak;
   int         cand;
   int         none_run;
   logic [4:0] exp_keycode;

   always #5 clk5 = ~clk5;

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
      .clk5  (clk5),
      .reset (reset),
      .kp    (kp)
   );

   always_comb begin
      kp.row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         kp.row_n[r] = ~|(keys[r*4 +: 4] & ~kp.col_n);
   end
   assign kp.btn_enter = keys[16];
   assign kp.btn_clear = keys[17];

   function automatic int classify(input logic [17:0] k);
      int n = 0;
      int idx = 0;
      for (int i = 0; i < 18; i++) if (k[i]) begin n++; idx = i; end
      if (n == 0) return -1;
      if (n > 1) return -2;
      if (idx == 16) return 'h10;
      if (idx == 17) return 'h11;
      return int'(code_tab[idx]);
   endfunction

   task automatic model_reset();
      armed = 1; streak = 0; cand = -1; none_run = 0; exp_keycode = 5'h00;
   endtask

   // One scan's worth of key state in; whether this scan must produce a strobe out.
   task automatic model_scan(input logic [17:0] k, output bit emit);
      int res = classify(k);
      emit = 0;
      if (!armed) begin
         none_run = (res == -1) ? none_run + 1 : 0;
         if (none_run == D) begin armed = 1; none_run = 0; end
      end else if (res >= 0) begin
         if (streak > 0 && res != cand) streak = 0;
         else begin
            if (streak == 0) cand = res;
            streak++;
            if (streak == D) begin
               emit = 1; armed = 0; streak = 0; exp_keycode = 5'(cand);
            end
         end
      end else begin
         streak = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk5);
      keys = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk5);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_scan(input logic [17:0] k);
      bit exp_nk;
      logic [3:0] exp_col;
      keys = k;
      model_scan(k, exp_nk);
      for (int i = 1; i <= SCAN; i++) begin
         @(posedge clk5); #1;
         cyc++;
         exp_col = ~(4'b0001 << ((i % SCAN) / 4));
         checks++;
         if (kp.col_n !== exp_col) begin
            errors++;
            $display("FAIL col_n cyc %0d: got %b expected %b", cyc, kp.col_n, exp_col);
         end
         checks++;
         if (kp.newkey !== ((i == SCAN) ? exp_nk : 1'b0)) begin
            errors++;
            $display("FAIL newkey cyc %0d: got %b expected %b", cyc, kp.newkey, (i == SCAN) ? exp_nk : 1'b0);
         end
         if (kp.newkey === 1'b1) begin
            pulses++;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
         end
      end
      checks++;
      if (kp.keycode !== exp_keycode) begin
         errors++;
         $display("FAIL keycode cyc %0d: got %h expected %h", cyc, kp.keycode, exp_keycode);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (kp.col_n !== 4'b1110 || kp.newkey !== 1'b0 || kp.keycode !== 5'h00) begin
         errors++;
         $display("FAIL reset_values: got %b/%b/%h expected 1110/0/00", kp.col_n, kp.newkey, kp.keycode);
      end
      @(negedge clk5);
      reset = 1'b0;
      model_reset();
      pulses = 0;
      do_scan(18'(1) << 6);
      do_scan(18'(1) << 6);
      repeat (5) @(posedge clk5);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (kp.col_n !== 4'b1110 || kp.newkey !== 1'b0 || kp.keycode !== 5'h00) begin
         errors++;
         $display("FAIL mid_reset: got %b/%b/%h expected 1110/0/00", kp.col_n, kp.newkey, kp.keycode);
      end
      keys = '0;
      @(negedge clk5);
      @(negedge clk5);
      reset = 1'b0;
      model_reset();
      repeat (4) do_scan('0);
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_discard: got %0d pulses expected 0", pulses);
      end
   endtask

   task automatic test_press_hold();
      int press_cyc;
      do_reset();
      pulses = 0;
      first_pulse_cyc = -1;
      press_cyc = cyc;
      repeat (20) do_scan(18'(1) << 6);
      checks++;
      if (first_pulse_cyc - press_cyc < 35 || first_pulse_cyc - press_cyc > 67) begin
         errors++;
         $display("FAIL press_latency: got %0d expected 35..67", first_pulse_cyc - press_cyc);
      end
      repeat (4) do_scan('0);
      repeat (4) do_scan(18'(1) << 6);
      checks++;
      if (pulses != 2 || kp.keycode !== 5'h06) begin
         errors++;
         $display("FAIL press_hold: got %0d pulses code %h expected 2 pulses code 06", pulses, kp.keycode);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      pulses = 0;
      for (int t = 0; t < 120 + 136 + 64; t++) begin
         if (t < 120) keys = (((t / 6) % 2) == 0) ? (18'(1) << 10) : '0;
         else if (t < 256) keys = 18'(1) << 10;
         else keys = '0;
         @(posedge clk5); #1;
         if (kp.newkey === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || kp.keycode !== 5'h09) begin
         errors++;
         $display("FAIL bounce: got %0d pulses code %h expected 1 pulse code 09", pulses, kp.keycode);
      end
   endtask

   task automatic test_multi();
      do_reset();
      pulses = 0;
      repeat (5) do_scan((18'(1) << 0) | (18'(1) << 5));
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL multi_hold: got %0d pulses expected 0", pulses);
      end
      repeat (5) do_scan(18'(1) << 5);
      repeat (4) do_scan('0);
      checks++;
      if (pulses != 1 || kp.keycode !== 5'h05) begin
         errors++;
         $display("FAIL multi_release: got %0d pulses code %h expected 1 pulse code 05", pulses, kp.keycode);
      end
   endtask

   task automatic test_buttons();
      do_reset();
      pulses = 0;
      repeat (4) do_scan(18'(1) << 16);
      repeat (4) do_scan((18'(1) << 16) | (18'(1) << 17));
      repeat (4) do_scan('0);
      checks++;
      if (pulses != 1 || kp.keycode !== 5'h10) begin
         errors++;
         $display("FAIL buttons: got %0d pulses code %h expected 1 pulse code 10", pulses, kp.keycode);
      end
   endtask

   task automatic test_short_press();
      do_reset();
      pulses = 0;
      repeat (4) do_scan(18'(1) << 2);
      repeat (4) do_scan('0);
      repeat (2) do_scan(18'(1) << 13);
      repeat (4) do_scan('0);
      checks++;
      if (pulses != 1 || kp.keycode !== 5'h03) begin
         errors++;
         $display("FAIL short_press: got %0d pulses code %h expected 1 pulse code 03", pulses, kp.keycode);
      end
   endtask

   task automatic test_random();
      int pool [4] = '{6, 10, 16, 13};
      logic [17:0] pat;
      int kind, a, b;
      do_reset();
      for (int run = 0; run < 40; run++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 4) pat = '0;
         else if (kind < 8) pat = 18'(1) << pool[$urandom_range(0, 3)];
         else begin
            a = int'($urandom_range(0, 17));
            b = (a + int'($urandom_range(1, 17))) % 18;
            pat = (18'(1) << a) | (18'(1) << b);
         end
         repeat ($urandom_range(1, 5)) do_scan(pat);
      end
   endtask

   initial begin
      test_reset();
      test_press_hold();
      test_bounce();
      test_multi();
      test_buttons();
      test_short_press();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
